// File: rtl/uart_rx_engine_if.sv
// uart_rx_engine_if: serial line, frame config, read strobe and received byte/status of the UART receiver
//   master (processor side): drives rx, bit_time, eight, pen, ohel, clr_rdy; reads data, status
//   slave  (receiver side):  reads rx, bit_time, eight, pen, ohel, clr_rdy; drives data, status
interface uart_rx_engine_if #(parameter int BT_W = 19);
  logic            rx;
  logic [BT_W-1:0] bit_time;
  logic            eight;
  logic            pen;
  logic            ohel;
  logic            clr_rdy;
  logic [7:0]      data;
  logic [7:0]      status;
  modport master (output rx, bit_time, eight, pen, ohel, clr_rdy, input data, status);
  modport slave  (input rx, bit_time, eight, pen, ohel, clr_rdy, output data, status);
endinterface

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART receiver sampling each bit mid-cell at a programmable bit time
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      slave modport: rx line, bit_time/eight/pen/ohel config and clr_rdy in; data and
//            status = {4'b0, ovf, ferr, perr, rxrdy} out
module uart_rx_engine #(parameter int BT_W = 19) (
  input logic             clk,
  input logic             reset_n,
  uart_rx_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_sync;
  logic            r_rxs_d;
  logic [BT_W-1:0] r_cnt, r_bits, r_kk;
  logic            r_eight, r_pen, r_ohel;
  logic [8:0]      r_sh;
  logic [7:0]      r_data;
  logic            r_rxrdy, r_ovf, r_ferr, r_perr;
  logic            w_rxs, w_fall, w_half, w_bit_end, w_last;
  logic            w_latch, w_sample, w_load, w_clr_cnt, w_par, w_perr;
  logic [7:0]      w_data;
  logic [BT_W-1:0] w_kk;
  assign w_rxs     = r_sync[1];
  assign w_fall    = r_rxs_d & ~w_rxs;
  assign w_kk      = bus.bit_time < BT_W'(4) ? BT_W'(4) : bus.bit_time;
  assign w_half    = r_cnt == (r_kk >> 1) - BT_W'(1);
  assign w_bit_end = r_cnt == r_kk - BT_W'(1);
  // samples taken before the stop bit: data bits plus optional parity
  assign w_last    = r_bits == BT_W'(r_eight ? 4'd8 : 4'd7) + BT_W'(r_pen);
  // pre-stop samples sit right-justified at the top of r_sh, parity (if any) in bit 8
  assign w_par     = r_sh[8];
  assign w_data    = r_pen ? (r_eight ? r_sh[7:0] : {1'b0, r_sh[7:1]})
                           : (r_eight ? r_sh[8:1] : {1'b0, r_sh[8:2]});
  assign w_perr    = r_pen & (((^w_data) ^ w_par) != r_ohel);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE  ? (w_fall ? START : IDLE)
           : r_state == START ? (w_half ? (w_rxs ? IDLE : SHIFT) : START)
           : (w_load ? IDLE : SHIFT);
  end
  always_comb begin
    w_latch   = r_state == IDLE && w_fall;
    w_sample  = r_state == SHIFT && w_bit_end;
    w_load    = w_sample && w_last;
    w_clr_cnt = r_state == IDLE || (r_state == START && w_half) || w_sample;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sync  <= 2'b11;
      r_rxs_d <= 1'b1;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_kk    <= BT_W'(4);
      r_eight <= 1'b0;
      r_pen   <= 1'b0;
      r_ohel  <= 1'b0;
      r_sh    <= '0;
      r_data  <= '0;
      r_rxrdy <= 1'b0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.rx};
      r_rxs_d <= w_rxs;
      r_cnt   <= w_clr_cnt ? '0 : r_cnt + BT_W'(1);
      r_bits  <= r_state != SHIFT ? '0 : r_bits + BT_W'(w_sample);
      if (w_latch) begin
        r_kk    <= w_kk;
        r_eight <= bus.eight;
        r_pen   <= bus.pen;
        r_ohel  <= bus.ohel;
      end
      if (w_sample) r_sh <= {w_rxs, r_sh[8:1]};
      // a completing frame takes priority over a coincident read strobe
      if (w_load) begin
        r_data  <= w_data;
        r_rxrdy <= 1'b1;
        r_ovf   <= r_rxrdy & ~bus.clr_rdy;
        r_ferr  <= ~w_rxs;
        r_perr  <= w_perr;
      end else if (bus.clr_rdy) begin
        r_rxrdy <= 1'b0;
        r_ovf   <= 1'b0;
        r_ferr  <= 1'b0;
        r_perr  <= 1'b0;
      end
    end
  assign bus.data   = r_data;
  assign bus.status = {4'b0000, r_ovf, r_ferr, r_perr, r_rxrdy};
endmodule
